// File: rtl/riscv_pkg.sv
// Shared RISC-V types and the commit-trace record layout used by commit_trace_streamer.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [5:0] {
    NOP, ADD, ADDI, SUB, AND, OR, XOR, LUI, AUIPC, JAL, JALR, BEQ, BNE,
    LB, LH, LW, LBU, LHU, SB, SH, SW
  } operation_e;

  localparam logic [2:0] TRACE_SYNC = 3'b101;

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_B    = 2'd1;
  localparam logic [1:0] SZ_H    = 2'd2;
  localparam logic [1:0] SZ_W    = 2'd3;

  typedef struct packed {
    logic            store;
    logic            load;
    logic            regw;
    logic [1:0]      size;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] maddr;
    logic [XLEN-1:0] mdata;
  } trace_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_PC, ST_INSTR, ST_RD, ST_RDATA, ST_MADDR, ST_MDATA
  } ser_state_e;

  function automatic logic [7:0] hdr_byte(input trace_rec_t r);
    return {TRACE_SYNC, r.store, r.load, r.regw, r.size};
  endfunction

  // Byte presented on the stream for a given field/byte index of a record.
  function automatic logic [7:0] rec_byte(input ser_state_e st, input logic [1:0] idx,
                                          input trace_rec_t r);
    logic [XLEN-1:0] w;
    w = '0;
    case (st)
      ST_PC:    w = r.pc;
      ST_INSTR: w = r.instr;
      ST_RDATA: w = r.rdata;
      ST_MADDR: w = r.maddr;
      ST_MDATA: w = r.mdata;
      default:  w = '0;
    endcase
    case (st)
      ST_HDR:  return hdr_byte(r);
      ST_RD:   return {3'b000, r.rd};
      default: return w[{idx, 3'b000} +: 8];
    endcase
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);

  T           r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        w_do_push, w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/commit_trace_streamer.sv
// Captures retired instructions into a record FIFO and serializes each record as a byte stream.
module commit_trace_streamer
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              update_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [4:0]        reg_addr_i,
  input  logic [XLEN-1:0]   reg_data_i,
  input  logic              register_file_write_enable_i,
  input  logic              memory_read_enable_i,
  input  logic              memory_write_enable_i,
  input  logic [XLEN-1:0]   memory_read_addr_i,
  input  logic [XLEN-1:0]   memory_write_addr_i,
  input  logic [XLEN-1:0]   memory_write_data_i,
  input  operation_e        operation_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              overflow_o,
  output logic [DROP_W-1:0] drop_count_o
);
  logic       w_cap, w_store, w_load, w_regw, w_full, w_empty, w_pop, w_drop, w_adv;
  logic [1:0] w_size;
  trace_rec_t w_rec, w_head;

  // Classification: store beats load beats register write.
  always_comb begin
    w_cap   = update_i && (pc_i != '0);
    w_store = memory_write_enable_i;
    w_load  = !w_store && memory_read_enable_i && (reg_addr_i != '0);
    w_regw  = !w_store && (w_load || (register_file_write_enable_i && (reg_addr_i != '0)));
    w_size  = SZ_NONE;
    if (w_store) begin
      case (operation_i)
        SB:      w_size = SZ_B;
        SH:      w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end
    w_rec.store = w_store;
    w_rec.load  = w_load;
    w_rec.regw  = w_regw;
    w_rec.size  = w_size;
    w_rec.pc    = pc_i;
    w_rec.instr = instr_i;
    w_rec.rd    = w_regw ? reg_addr_i : '0;
    w_rec.rdata = w_regw ? reg_data_i : '0;
    w_rec.maddr = w_store ? memory_write_addr_i : (w_load ? memory_read_addr_i : '0);
    case (w_size)
      SZ_B:    w_rec.mdata = {24'd0, memory_write_data_i[7:0]};
      SZ_H:    w_rec.mdata = {16'd0, memory_write_data_i[15:0]};
      SZ_W:    w_rec.mdata = memory_write_data_i;
      default: w_rec.mdata = '0;
    endcase
  end

  trace_fifo #(.T(trace_rec_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_cap),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  ser_state_e r_state, w_nxt_state, w_seq;
  logic [1:0] r_idx, w_nxt_idx;
  trace_rec_t r_rec, w_nxt_rec;
  logic [7:0] r_tx_data, w_nxt_data;
  logic       r_tx_valid, w_nxt_valid;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_rec   = r_rec;
    w_nxt_data  = r_tx_data;
    w_nxt_valid = r_tx_valid;
    w_pop       = 1'b0;
    w_adv       = (r_state == ST_IDLE) || (r_tx_valid && tx_ready_i);
    // w_seq is the field holding the next byte; ST_IDLE means the record is finished.
    case (r_state)
      ST_HDR:   w_seq = ST_PC;
      ST_PC:    w_seq = (r_idx != 2'd3) ? ST_PC : ST_INSTR;
      ST_INSTR: w_seq = (r_idx != 2'd3) ? ST_INSTR :
                        r_rec.regw ? ST_RD : (r_rec.store ? ST_MADDR : ST_IDLE);
      ST_RD:    w_seq = ST_RDATA;
      ST_RDATA: w_seq = (r_idx != 2'd3) ? ST_RDATA : (r_rec.load ? ST_MADDR : ST_IDLE);
      ST_MADDR: w_seq = (r_idx != 2'd3) ? ST_MADDR : (r_rec.store ? ST_MDATA : ST_IDLE);
      ST_MDATA: w_seq = (r_idx != 2'd3) ? ST_MDATA : ST_IDLE;
      default:  w_seq = ST_IDLE;
    endcase
    if (w_adv) begin
      if (w_seq == ST_IDLE) begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_rec   = w_head;
          w_nxt_state = ST_HDR;
          w_nxt_idx   = 2'd0;
          w_nxt_data  = hdr_byte(w_head);
          w_nxt_valid = 1'b1;
        end else begin
          w_nxt_state = ST_IDLE;
          w_nxt_idx   = 2'd0;
          w_nxt_valid = 1'b0;
        end
      end else begin
        w_nxt_state = w_seq;
        w_nxt_idx   = (w_seq == r_state) ? r_idx + 2'd1 : 2'd0;
        w_nxt_data  = rec_byte(w_seq, w_nxt_idx, r_rec);
        w_nxt_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_rec      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_rec      <= w_nxt_rec;
      r_tx_data  <= w_nxt_data;
      r_tx_valid <= w_nxt_valid;
    end
  end

  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  assign w_drop = w_cap && w_full && !w_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign tx_data_o    = r_tx_data;
  assign tx_valid_o   = r_tx_valid;
  assign overflow_o   = r_overflow;
  assign drop_count_o = r_drop_cnt;
endmodule

// File: doc/commit_trace_streamer.md
# commit_trace_streamer

Captures every retired instruction from `core_model` (pc, instr, register write-back, memory access) into a record FIFO and serializes each record as a byte stream over a valid/ready interface. It is the producer side of the commit log: the same retirement information the bench prints as text is emitted in hardware, for a UART/debug bridge or an on-chip trace buffer. It sits beside `core_model` and observes only; it never stalls the core.

## Interface

Parameters:
- `DEPTH`, 8: record FIFO entries (power of 2, ≥2).
- `DROP_W`, 16: width of the dropped-record counter.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset. One clock; reset is asynchronous and active-low.
- `update_i` in 1: an instruction retires this cycle.
- `pc_i` in XLEN: retiring PC.
- `instr_i` in XLEN: retiring instruction word.
- `reg_addr_i` in 5: rd index.
- `reg_data_i` in XLEN: rd write-back value (load data for loads).
- `register_file_write_enable_i` in 1: rd is written.
- `memory_read_enable_i` in 1: instruction is a load.
- `memory_write_enable_i` in 1: instruction is a store.
- `memory_read_addr_i` in XLEN: load address.
- `memory_write_addr_i` in XLEN: store address.
- `memory_write_data_i` in XLEN: store data.
- `operation_i` in `riscv_pkg::operation_e`: decoded operation, used for store size.
- `tx_data_o` out 8: stream byte.
- `tx_valid_o` out 1: byte valid.
- `tx_ready_i` in 1: sink accepts the byte.
- `overflow_o` out 1: sticky, set when any record has been dropped.
- `drop_count_o` out DROP_W: saturating count of dropped records.

## Operation

- Capture condition: `update_i && pc_i != 0`, sampled at posedge.
- Record classification, in priority order:
  - Store: `memory_write_enable_i`. Size comes from `operation_i`: SB→1, SH→2, SW→3.
  - Load: `memory_read_enable_i && reg_addr_i != 0`.
  - Register write: `register_file_write_enable_i && reg_addr_i != 0`.
  - Otherwise a plain record (branch, x0 write, nop).
- Header byte:
  - bits[7:5] = 3'b101 (sync).
  - bit4 = store.
  - bit3 = load.
  - bit2 = register write (also set for load).
  - bits[1:0] = store size, 0 if not a store.
- Byte order on the stream:
  - HDR.
  - PC, 4 bytes, little-endian.
  - INSTR, 4 bytes LE.
  - If bit2: RD (1 byte, zero-extended index), then RDATA (4 bytes LE).
  - If load: MADDR = read address, 4 bytes LE.
  - If store: MADDR = write address (4 bytes LE), then MDATA (4 bytes LE, masked to size, upper bits zero).
- Record lengths:
  - Plain: 9 bytes.
  - Register write: 14 bytes.
  - Load: 18 bytes.
  - Store: 17 bytes.
- Serializer FSM states: IDLE, HDR, PC, INSTR, RD, RDATA, MADDR, MDATA.
  - A 2-bit byte index counts 0..3 inside each multi-byte field.
  - IDLE→HDR when the FIFO is non-empty. This pops the head into the serializer holding register.
  - Each state advances only on `tx_valid_o && tx_ready_i`.
  - Fields not present in the record are skipped.
  - After the last byte: go to HDR if the FIFO is non-empty (pop in the same cycle), else go to IDLE.
- `tx_data_o` is stable while `tx_valid_o && !tx_ready_i`.
- FIFO full with a capture and no pop in the same cycle: the record is dropped, `overflow_o` is set, and `drop_count_o` increments, saturating at all-ones.
  - A capture while full is accepted if a pop occurs in the same cycle.
- No flush path. A record partially sent is always completed.

## Timing

- Reset values:
  - `tx_valid_o` = 0, `tx_data_o` = 0.
  - `overflow_o` = 0, `drop_count_o` = 0.
  - FIFO empty, FSM in IDLE.
- Reset asserted mid-record discards the FIFO and the partial record immediately. The stream restarts with a fresh HDR.
- Latency: capture at edge E0 → record in FIFO after E0 → popped at E1 → `tx_valid_o`=1 with HDR after E1.
- Throughput with `tx_ready_i` held high: one byte per cycle, with no bubble between back-to-back records.
- All outputs are registered.

## Structure

- `riscv_pkg` holds:
  - `trace_rec_t`: packed struct of header flags, size, pc, instr, rd, rdata, maddr, mdata.
  - `TRACE_SYNC` = 3'b101.
  - Size encodings.
- Sub-module `trace_fifo`: synchronous FIFO parameterized by type/DEPTH, with push/pop/full/empty and simultaneous push-pop when full.
- Top module: classification logic, serializer FSM, drop counter.

## Test plan

- ALU retire: pc=0x80000004, instr=0x00500093, x1=5, `tx_ready_i`=1.
  - → 14 bytes: 0xA4, 04 00 00 80, 93 00 50 00, 01, 05 00 00 00. `tx_valid_o` first high 2 edges after capture.
- SB: addr 0x80001000, data 0x12345678 → header 0xB1; MADDR 00 10 00 80; MDATA 78 00 00 00.
- Load into x0: rd=0 with `memory_read_enable_i`.
  - → 9-byte plain record with header 0xA0. A capture with pc=0 emits nothing.
- Backpressure: `tx_ready_i` toggled randomly during a 5-record burst.
  - → byte sequence identical to the `tx_ready_i`=1 case; `tx_data_o` stable while stalled.
- Overflow: `tx_ready_i`=0, 12 consecutive plain retires with DEPTH=8.
  - → 9 records held (8 FIFO + 1 in the serializer); `drop_count_o`=3; `overflow_o`=1.
- Reset mid-record: `rstn` pulsed low after byte 5 of a record.
  - → `tx_valid_o` goes 0 asynchronously; FIFO empty; the next capture starts with a sync header.
